spy_event_reader: RTL and testbench
===================================

Name: spy_event_reader

Overview:
- Readout engine downstream of the spy controller.
- While the spy buffer is frozen, on request it walks the event list backwards from the newest entry and locates the most recent complete event: the span between the last two start-of-event entries.
- It checks that span against spy-memory wrap-around, then streams the span out of spy memory on a valid/ready interface, with status.
- Replaces ad-hoc address poking for software or block-transfer readout.

Parameters:
- DATAWIDTH, 32, spy data width excluding metadata bit (stream word is DATAWIDTH+1).
- MEMWIDTH, 6, spy memory address width; depth 2**MEMWIDTH.
- METAWIDTH, 4, event list address width; depth 2**METAWIDTH.

Ports:
- clock  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- freeze  in  1  same freeze level driving the spy controller.
- start  in  1  one-cycle request pulse.
- mem_wptr  in  MEMWIDTH  spy memory write pointer (next slot).
- meta_write_addr  in  METAWIDTH  event list write pointer (next slot).
- meta_looped  in  1  event list has wrapped at least once (metalist looped output, now routed out).
- meta_read_addr  out  METAWIDTH  event list read address.
- meta_read_enable  out  1  event list read strobe.
- meta_read_data  in  MEMWIDTH+1  {sentinel, spy address}; valid 1 cycle after strobe.
- read_addr  out  MEMWIDTH  spy memory read address.
- read_enable  out  1  spy memory read strobe.
- data_out  in  DATAWIDTH+1  spy memory read data; valid 1 cycle after strobe.
- out_data  out  DATAWIDTH+1  streamed event word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  sink accepts.
- out_last  out  1  final word of event, qualified by out_valid.
- busy  out  1  not IDLE.
- done  out  1  one-cycle completion pulse.
- status  out  2  00 ok, 01 no complete event, 10 overwritten, 11 aborted; held until next start.

Behaviour:
- Reset: state IDLE; all outputs 0, including status; internal FIFO empty.
- start is honoured only in IDLE with freeze=1; otherwise ignored with no status change.
- On accept:
  - Latch mem_wptr as W.
  - Set scan limit L = meta_looped ? 2**METAWIDTH-1 : meta_write_addr.
  - Set index i = meta_write_addr-1 (mod 2**METAWIDTH), sentinel count S=0, SOE found count F=0.
  - Clear status.
- SCAN_REQ: drive meta_read_enable=1, meta_read_addr=i. Go to SCAN_WAIT.
- SCAN_WAIT: examine meta_read_data.
  - Sentinel bit=1 and F≥1: S++ (saturate at 2).
  - Sentinel bit=1 and F=0: ignore.
  - Sentinel bit=0, first hit: END=addr, F=1.
  - Sentinel bit=0, second hit: BEGIN=addr, F=2, go to CHECK.
  - Otherwise decrement i, increment scanned count. If scanned=L, go to DONE with status 01; else go to SCAN_REQ.
  - L=0 means DONE with status 01 immediately, with no reads.
- CHECK (1 cycle) evaluates in this order:
  - S≥2: status 10.
  - S=1 and BEGIN<W: status 10.
  - Otherwise LEN = (END-BEGIN) mod 2**MEMWIDTH; LEN=0 means 2**MEMWIDTH.
  - Go to DONE on error, else STREAM.
- STREAM:
  - Read pointer starts at BEGIN; remaining = LEN.
  - Issue read_enable when remaining>0 and (FIFO count + in-flight) < 2.
  - Pointer increments mod 2**MEMWIDTH.
  - Data is pushed into a 2-entry output FIFO the cycle after issue.
  - Sustained 1 word/cycle when out_ready is held at 1.
  - out_data/out_valid come from the FIFO head; a word is consumed on out_valid & out_ready.
  - out_valid/out_data stable while out_ready=0.
  - out_last=1 on word LEN of LEN.
  - Go to DONE when the last word is consumed; status 00.
- DONE: done=1 for one cycle, then IDLE. busy=0 in IDLE only.
- Freeze drop: freeze=0 in any non-IDLE state takes effect the next cycle.
  - Stop issuing reads; drop in-flight and FIFO words; out_valid=0.
  - Go to DONE with status 11 (takes priority over any other status that cycle).
- start while busy is ignored.
- Async reset mid-operation returns immediately to the reset state; no done pulse.

Test Plan:
- Defaults; event list {0,0x05},{0,0x0C}; meta_write_addr=2; W=0x14; freeze, start, out_ready=1 -> 7 words from spy addresses 0x05..0x0B on consecutive cycles, out_last on 7th, done, status 00.
- Event list {0,0x3C},{1,0x00},{0,0x04}; W=0x08 -> BEGIN 0x3C ≥ W, 8 words at 0x3C..0x3F,0x00..0x03, status 00. Same list with W=0x3E -> no data, status 10.
- Single SOE entry only (meta_write_addr=1, meta_looped=0) -> 1 meta read, no out_valid, done, status 01. meta_write_addr=0 -> done within 2 cycles, status 01.
- First case with out_ready toggling 1,0,0,1 repeatedly -> all 7 words delivered in order, none duplicated, out_data stable during stall.
- Deassert freeze on 3rd streamed word -> out_valid 0 next cycle, done, status 11; a start with freeze=0 afterwards is ignored.
- Assert reset during STREAM -> all outputs 0 asynchronously; a fresh start after release gives the correct full event.

Source files
------------

// File: rtl/spy_event_reader.sv
// Readout engine for a frozen spy buffer: finds the newest complete event in the
// event list, checks it against spy-memory wrap-around and streams it out.
module spy_event_reader #(
  parameter int DATAWIDTH = 32,
  parameter int MEMWIDTH  = 6,
  parameter int METAWIDTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 freeze,
  input  logic                 start,
  input  logic [MEMWIDTH-1:0]  mem_wptr,
  input  logic [METAWIDTH-1:0] meta_write_addr,
  input  logic                 meta_looped,
  output logic [METAWIDTH-1:0] meta_read_addr,
  output logic                 meta_read_enable,
  input  logic [MEMWIDTH:0]    meta_read_data,
  output logic [MEMWIDTH-1:0]  read_addr,
  output logic                 read_enable,
  input  logic [DATAWIDTH:0]   data_out,
  output logic [DATAWIDTH:0]   out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           status
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SCAN_REQ  = 3'd1,
    SCAN_WAIT = 3'd2,
    CHECK     = 3'd3,
    STREAM    = 3'd4,
    DONE      = 3'd5
  } state_t;

  localparam logic [1:0] STATUS_OK      = 2'b00;
  localparam logic [1:0] STATUS_NOEVENT = 2'b01;
  localparam logic [1:0] STATUS_OVWR    = 2'b10;
  localparam logic [1:0] STATUS_ABORT   = 2'b11;

  localparam logic [METAWIDTH-1:0] META_ONE = {{(METAWIDTH-1){1'b0}}, 1'b1};
  localparam logic [MEMWIDTH-1:0]  MEM_ONE  = {{(MEMWIDTH-1){1'b0}}, 1'b1};
  localparam logic [MEMWIDTH:0]    LEN_ONE  = {{MEMWIDTH{1'b0}}, 1'b1};

  state_t                 state_r;
  logic [MEMWIDTH-1:0]    w_r;
  logic [METAWIDTH-1:0]   limit_r;
  logic [METAWIDTH-1:0]   idx_r;
  logic [METAWIDTH-1:0]   scanned_r;
  logic [1:0]             sent_r;
  logic [1:0]             found_r;
  logic [MEMWIDTH-1:0]    end_r;
  logic [MEMWIDTH-1:0]    begin_r;
  logic [MEMWIDTH-1:0]    ptr_r;
  logic [MEMWIDTH:0]      rem_r;
  logic [MEMWIDTH:0]      left_r;
  logic [1:0]             status_r;
  logic [DATAWIDTH:0]     fifo_r [2];
  logic                   rd_r;
  logic                   wr_r;
  logic [1:0]             count_r;
  logic                   inflight_r;

  logic                   sentinel_s;
  logic [MEMWIDTH-1:0]    entry_addr_s;
  logic [METAWIDTH-1:0]   limit_s;
  logic [MEMWIDTH-1:0]    diff_s;
  logic [MEMWIDTH:0]      len_s;
  logic [2:0]             occ_s;
  logic                   pop_s;
  logic                   issue_s;

  // Scan decode, event length and read-issue decision for the output FIFO
  always_comb begin
    sentinel_s   = meta_read_data[MEMWIDTH];
    entry_addr_s = meta_read_data[MEMWIDTH-1:0];
    if (meta_looped) begin
      limit_s = {METAWIDTH{1'b1}};
    end else begin
      limit_s = meta_write_addr;
    end
    diff_s = end_r - begin_r;
    // A zero difference means the event spans the whole spy memory
    if (diff_s == {MEMWIDTH{1'b0}}) begin
      len_s = {1'b1, {MEMWIDTH{1'b0}}};
    end else begin
      len_s = {1'b0, diff_s};
    end
    occ_s = {1'b0, count_r} + {2'b00, inflight_r};
    if ((state_r == STREAM) && (count_r != 2'd0) && out_ready) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
    // Counting this cycle's pop keeps one word per cycle with a 2-deep FIFO
    if ((state_r == STREAM) && (rem_r != {(MEMWIDTH+1){1'b0}})) begin
      if (pop_s) begin
        issue_s = (occ_s < 3'd3);
      end else begin
        issue_s = (occ_s < 3'd2);
      end
    end else begin
      issue_s = 1'b0;
    end
  end

  assign meta_read_addr   = idx_r;
  assign meta_read_enable = (state_r == SCAN_REQ);
  assign read_addr        = ptr_r;
  assign read_enable      = issue_s;
  assign out_valid        = (state_r == STREAM) && (count_r != 2'd0);
  assign out_data         = out_valid ? fifo_r[rd_r] : {(DATAWIDTH+1){1'b0}};
  assign out_last         = out_valid && (left_r == LEN_ONE);
  assign busy             = (state_r != IDLE);
  assign done             = (state_r == DONE);
  assign status           = status_r;

  // Readout state machine, event-list scan registers and output FIFO
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      w_r        <= {MEMWIDTH{1'b0}};
      limit_r    <= {METAWIDTH{1'b0}};
      idx_r      <= {METAWIDTH{1'b0}};
      scanned_r  <= {METAWIDTH{1'b0}};
      sent_r     <= 2'd0;
      found_r    <= 2'd0;
      end_r      <= {MEMWIDTH{1'b0}};
      begin_r    <= {MEMWIDTH{1'b0}};
      ptr_r      <= {MEMWIDTH{1'b0}};
      rem_r      <= {(MEMWIDTH+1){1'b0}};
      left_r     <= {(MEMWIDTH+1){1'b0}};
      status_r   <= STATUS_OK;
      fifo_r[0]  <= {(DATAWIDTH+1){1'b0}};
      fifo_r[1]  <= {(DATAWIDTH+1){1'b0}};
      rd_r       <= 1'b0;
      wr_r       <= 1'b0;
      count_r    <= 2'd0;
      inflight_r <= 1'b0;
    end else if ((state_r != IDLE) && (state_r != DONE) && !freeze) begin
      state_r    <= DONE;
      status_r   <= STATUS_ABORT;
      count_r    <= 2'd0;
      inflight_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start && freeze) begin
            w_r        <= mem_wptr;
            limit_r    <= limit_s;
            idx_r      <= meta_write_addr - META_ONE;
            scanned_r  <= {METAWIDTH{1'b0}};
            sent_r     <= 2'd0;
            found_r    <= 2'd0;
            rd_r       <= 1'b0;
            wr_r       <= 1'b0;
            count_r    <= 2'd0;
            inflight_r <= 1'b0;
            if (limit_s == {METAWIDTH{1'b0}}) begin
              state_r  <= DONE;
              status_r <= STATUS_NOEVENT;
            end else begin
              state_r  <= SCAN_REQ;
              status_r <= STATUS_OK;
            end
          end
        end
        SCAN_REQ: begin
          state_r <= SCAN_WAIT;
        end
        SCAN_WAIT: begin
          if (!sentinel_s && (found_r == 2'd1)) begin
            begin_r <= entry_addr_s;
            found_r <= 2'd2;
            state_r <= CHECK;
          end else begin
            // Sentinels newer than the newest start-of-event are irrelevant
            if (sentinel_s) begin
              if ((found_r != 2'd0) && (sent_r != 2'd2)) begin
                sent_r <= sent_r + 2'd1;
              end
            end else begin
              end_r   <= entry_addr_s;
              found_r <= 2'd1;
            end
            idx_r     <= idx_r - META_ONE;
            scanned_r <= scanned_r + META_ONE;
            if ((scanned_r + META_ONE) == limit_r) begin
              state_r  <= DONE;
              status_r <= STATUS_NOEVENT;
            end else begin
              state_r <= SCAN_REQ;
            end
          end
        end
        CHECK: begin
          if (sent_r >= 2'd2) begin
            state_r  <= DONE;
            status_r <= STATUS_OVWR;
          end else if ((sent_r == 2'd1) && (begin_r < w_r)) begin
            state_r  <= DONE;
            status_r <= STATUS_OVWR;
          end else begin
            ptr_r   <= begin_r;
            rem_r   <= len_s;
            left_r  <= len_s;
            state_r <= STREAM;
          end
        end
        STREAM: begin
          if (issue_s) begin
            ptr_r <= ptr_r + MEM_ONE;
            rem_r <= rem_r - LEN_ONE;
          end
          inflight_r <= issue_s;
          if (inflight_r) begin
            fifo_r[wr_r] <= data_out;
            wr_r         <= ~wr_r;
          end
          count_r <= count_r + {1'b0, inflight_r} - {1'b0, pop_s};
          if (pop_s) begin
            rd_r   <= ~rd_r;
            left_r <= left_r - LEN_ONE;
            if (left_r == LEN_ONE) begin
              state_r  <= DONE;
              status_r <= STATUS_OK;
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spy_event_reader.sv
// Directed bench for spy_event_reader: models the event list and spy memory as
// one-cycle synchronous reads and checks each readout against hand-derived values.
module tb_spy_event_reader;

  localparam int DW = 32;
  localparam int MW = 6;
  localparam int XW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          freeze;
  logic          start;
  logic [MW-1:0] mem_wptr;
  logic [XW-1:0] meta_write_addr;
  logic          meta_looped;
  logic [XW-1:0] meta_read_addr;
  logic          meta_read_enable;
  logic [MW:0]   meta_read_data = '0;
  logic [MW-1:0] read_addr;
  logic          read_enable;
  logic [DW:0]   data_out = '0;
  logic [DW:0]   out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          done;
  logic [1:0]    status;

  int checks = 0;
  int failures = 0;

  logic [MW:0] meta_mem [16];
  logic [DW:0] got_q [$];
  logic        last_q [$];
  int          hs_q [$];
  int          meta_reads;
  int          done_at;
  logic        saw_done;
  logic [1:0]  done_status;

  spy_event_reader #(.DATAWIDTH(DW), .MEMWIDTH(MW), .METAWIDTH(XW)) dut (
    .clock(clock), .reset(reset), .freeze(freeze), .start(start),
    .mem_wptr(mem_wptr), .meta_write_addr(meta_write_addr), .meta_looped(meta_looped),
    .meta_read_addr(meta_read_addr), .meta_read_enable(meta_read_enable),
    .meta_read_data(meta_read_data), .read_addr(read_addr), .read_enable(read_enable),
    .data_out(data_out), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done), .status(status)
  );

  always #5 clock = ~clock;

  function automatic logic [DW:0] spy_word(input logic [MW-1:0] a);
    return {a[0], 16'hC0DE, 10'h000, a};
  endfunction

  always @(posedge clock) if (meta_read_enable) meta_read_data <= meta_mem[meta_read_addr];
  always @(posedge clock) if (read_enable) data_out <= spy_word(read_addr);

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pulse start, then watch outputs each cycle until done or stop_after words
  task automatic run_event(input int ready_mode, input int stop_after);
    logic [DW+1:0] prev;
    logic          prev_stall;
    got_q.delete(); last_q.delete(); hs_q.delete();
    meta_reads = 0; saw_done = 1'b0; done_at = -1; done_status = 2'b00;
    prev = '0; prev_stall = 1'b0;
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (ready_mode == 0) out_ready = 1'b1;
      else out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      @(negedge clock);
      if (meta_read_enable) meta_reads++;
      if (prev_stall) check_value("stall_hold", {out_valid, out_data}, prev);
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        last_q.push_back(out_last);
        hs_q.push_back(cyc);
      end
      prev_stall = out_valid && !out_ready;
      prev = {out_valid, out_data};
      if (done) begin
        saw_done = 1'b1;
        done_at = cyc;
        done_status = status;
      end
      @(posedge clock); #1;
      if (saw_done) break;
      if (stop_after > 0 && got_q.size() == stop_after) break;
    end
    if (stop_after == 0) check_value("done_seen", saw_done, 1);
  endtask

  task automatic verify_words(input logic [MW-1:0] first, input int len);
    check_value("word_count", got_q.size(), len);
    for (int k = 0; k < got_q.size() && k < len; k++) begin
      logic [MW-1:0] a;
      a = first + k[MW-1:0];
      check_value("word_data", got_q[k], spy_word(a));
      check_value("word_last", last_q[k], (k == len - 1));
    end
  endtask

  task automatic setup_basic();
    for (int k = 0; k < 16; k++) meta_mem[k] = '0;
    meta_mem[0] = {1'b0, 6'h05};
    meta_mem[1] = {1'b0, 6'h0C};
    meta_write_addr = 4'd2;
    meta_looped = 1'b0;
    mem_wptr = 6'h14;
    freeze = 1'b1;
  endtask

  initial begin
    int span;
    reset = 1'b0; start = 1'b0; freeze = 1'b0; mem_wptr = '0;
    meta_write_addr = '0; meta_looped = 1'b0; out_ready = 1'b0;
    for (int k = 0; k < 16; k++) meta_mem[k] = '0;
    repeat (3) @(posedge clock);
    #1;
    check_value("reset_outputs", {busy, done, status, out_valid, out_last, read_enable,
                meta_read_enable, meta_read_addr, read_addr, out_data}, 0);
    @(negedge clock) reset = 1'b1;

    // Basic event: 7 words from 0x05, back to back
    setup_basic();
    run_event(0, 0);
    check_value("basic_status", done_status, 2'b00);
    check_value("basic_meta_reads", meta_reads, 2);
    verify_words(6'h05, 7);
    if (hs_q.size() > 0) span = hs_q[hs_q.size()-1] - hs_q[0];
    else span = -1;
    check_value("basic_consecutive", span, 6);
    check_value("basic_idle_after", busy, 0);

    // Wrapped event with one sentinel, BEGIN at or above W
    meta_mem[0] = {1'b0, 6'h3C};
    meta_mem[1] = {1'b1, 6'h00};
    meta_mem[2] = {1'b0, 6'h04};
    meta_write_addr = 4'd3;
    mem_wptr = 6'h08;
    run_event(0, 0);
    check_value("wrap_status", done_status, 2'b00);
    check_value("wrap_meta_reads", meta_reads, 3);
    verify_words(6'h3C, 8);

    // Same list, but the writer has overtaken BEGIN
    mem_wptr = 6'h3E;
    run_event(0, 0);
    check_value("ovwr_status", done_status, 2'b10);
    check_value("ovwr_words", got_q.size(), 0);

    // Only one start-of-event entry
    meta_mem[0] = {1'b0, 6'h10};
    meta_write_addr = 4'd1;
    run_event(0, 0);
    check_value("single_status", done_status, 2'b01);
    check_value("single_meta_reads", meta_reads, 1);
    check_value("single_words", got_q.size(), 0);

    // Empty list: finishes without any read
    meta_write_addr = 4'd0;
    run_event(0, 0);
    check_value("empty_status", done_status, 2'b01);
    check_value("empty_meta_reads", meta_reads, 0);
    check_value("empty_fast_done", (done_at >= 0) && (done_at <= 1), 1);

    // Back-pressure pattern 1,0,0,1
    setup_basic();
    run_event(1, 0);
    check_value("stall_status", done_status, 2'b00);
    verify_words(6'h05, 7);

    // Freeze drop after the third word
    setup_basic();
    run_event(0, 3);
    freeze = 1'b0;
    out_ready = 1'b0;
    check_value("abort_words", got_q.size(), 3);
    @(negedge clock);
    @(posedge clock); #1;
    @(negedge clock);
    check_value("abort_valid", out_valid, 0);
    check_value("abort_done", done, 1);
    check_value("abort_status", status, 2'b11);
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    @(negedge clock);
    check_value("nofreeze_start_busy", busy, 0);
    check_value("nofreeze_start_status", status, 2'b11);

    // Asynchronous reset in the middle of streaming, then a clean rerun
    setup_basic();
    run_event(0, 2);
    #2 reset = 1'b0;
    #1;
    check_value("midreset_outputs", {busy, done, status, out_valid, out_last, read_enable,
                meta_read_enable, out_data}, 0);
    @(negedge clock) reset = 1'b1;
    run_event(0, 0);
    check_value("rerun_status", done_status, 2'b00);
    verify_words(6'h05, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
